// File: rtl/lsu_dmem_bridge_pkg.sv
// Shared types for the LSU data-memory bridge: the registered bus request slot
// and the address window helper.
package lsu_dmem_bridge_pkg;

  localparam int MemW = 33;

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic            is_cap;
    logic [31:0]     addr;
    logic [MemW-1:0] wdata;
  } dmem_req_t;

  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/lsu_dmem_bridge_chk.sv
// Checker for lsu_dmem_bridge: the in-flight bus count must stay within the limit.
module lsu_dmem_bridge_chk #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntW           = 2
) (
  input logic            clk_i,
  input logic            rst_ni,
  input logic [CntW-1:0] outstanding_i
);

  // Bus transaction count is bounded by the accept rule
  a_outstanding_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_i <= CntW'(MaxOutstanding));

endmodule

// File: rtl/lsu_dmem_bridge.sv
// Bridge from the LSU data port to the data-side bus: one registered request slot,
// bounded in-flight count, in-order responses and local rejection of out-of-window accesses.
module lsu_dmem_bridge
  import lsu_dmem_bridge_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RangeEn        = 1'b1,
  parameter logic [31:0] RangeBase      = 32'h8000_0000,
  parameter logic [31:0] RangeMask      = 32'hF000_0000,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [3:0]      lsu_be_i,
  input  logic            lsu_is_cap_i,
  input  logic [31:0]     lsu_addr_i,
  input  logic [MemW-1:0] lsu_wdata_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic            lsu_err_o,
  output logic [MemW-1:0] lsu_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic            mem_is_cap_o,
  output logic [31:0]     mem_addr_o,
  output logic [MemW-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic            mem_err_i,
  input  logic [MemW-1:0] mem_rdata_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            proto_err_o
);

  localparam int unsigned TotW = CntW + 1;

  dmem_req_t       slot_q;
  logic            slot_valid_q;
  logic [CntW-1:0] outstanding_q;
  logic            err_pend_q;
  logic            proto_err_q;

  logic            in_range;
  logic            mem_fire;
  logic            rsp_ok;
  logic            spurious;
  logic            bus_accept;
  logic            local_reject;
  logic [TotW-1:0] total_eff;

  // Accept/reject decision; a response retiring this cycle frees its credit immediately
  always_comb begin
    in_range     = !RangeEn || addr_in_window(lsu_addr_i, RangeBase, RangeMask);
    mem_fire     = slot_valid_q & mem_gnt_i;
    rsp_ok       = mem_rvalid_i & (outstanding_q != '0);
    spurious     = mem_rvalid_i & (outstanding_q == '0);
    total_eff    = TotW'(outstanding_q) + TotW'(slot_valid_q) - TotW'(rsp_ok);
    bus_accept   = lsu_req_i & in_range & ~err_pend_q
                 & (total_eff < TotW'(MaxOutstanding))
                 & (~slot_valid_q | mem_gnt_i);
    local_reject = lsu_req_i & ~in_range & ~err_pend_q & (total_eff == '0);
  end

  assign lsu_gnt_o     = rst_ni & (bus_accept | local_reject);
  assign lsu_rvalid_o  = err_pend_q | rsp_ok;
  assign lsu_err_o     = err_pend_q | (rsp_ok & mem_err_i);
  assign lsu_rdata_o   = rsp_ok ? mem_rdata_i : '0;

  assign mem_req_o     = slot_valid_q;
  assign mem_we_o      = slot_q.we;
  assign mem_be_o      = slot_q.be;
  assign mem_is_cap_o  = slot_q.is_cap;
  assign mem_addr_o    = slot_q.addr;
  assign mem_wdata_o   = slot_q.wdata;
  assign outstanding_o = outstanding_q;
  assign proto_err_o   = proto_err_q;

  // Request slot: loads on accept, empties when the bus takes it, otherwise holds
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
    end else if (bus_accept) begin
      slot_valid_q <= 1'b1;
      slot_q       <= '{we: lsu_we_i, be: lsu_be_i, is_cap: lsu_is_cap_i,
                        addr: lsu_addr_i, wdata: lsu_wdata_i};
    end else if (mem_fire) begin
      slot_valid_q <= 1'b0;
    end
  end

  // Bookkeeping for in-flight count, pending local error and protocol violation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      err_pend_q    <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_q + CntW'(mem_fire) - CntW'(rsp_ok);
      err_pend_q    <= local_reject;
      proto_err_q   <= proto_err_q | spurious;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_bridge.sv
// Randomized bench for lsu_dmem_bridge against a queue-based transaction model.
module tb_lsu_dmem_bridge;
  import lsu_dmem_bridge_pkg::*;

  localparam int MaxOut = 2;
  localparam int CntW   = $clog2(MaxOut + 1);

  typedef struct {
    logic            we;
    logic [3:0]      be;
    logic            is_cap;
    logic [31:0]     addr;
    logic [MemW-1:0] wdata;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            lsu_req, lsu_we, lsu_is_cap;
  logic [3:0]      lsu_be;
  logic [31:0]     lsu_addr;
  logic [MemW-1:0] lsu_wdata;
  logic            lsu_gnt, lsu_rvalid, lsu_err;
  logic [MemW-1:0] lsu_rdata;
  logic            mem_req, mem_we, mem_is_cap;
  logic [3:0]      mem_be;
  logic [31:0]     mem_addr;
  logic [MemW-1:0] mem_wdata;
  logic            mem_gnt, mem_rvalid, mem_err;
  logic [MemW-1:0] mem_rdata;
  logic [CntW-1:0] outstanding;
  logic            proto_err;

  always #5 clk = ~clk;

  lsu_dmem_bridge #(
    .MaxOutstanding(MaxOut), .RangeEn(1'b1),
    .RangeBase(32'h8000_0000), .RangeMask(32'hF000_0000)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
    .lsu_is_cap_i(lsu_is_cap), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid), .lsu_err_o(lsu_err),
    .lsu_rdata_o(lsu_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_is_cap_o(mem_is_cap), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_err_i(mem_err),
    .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .proto_err_o(proto_err)
  );

  lsu_dmem_bridge_chk #(.MaxOutstanding(MaxOut), .CntW(CntW)) chk_i (
    .clk_i(clk), .rst_ni(rst_ni), .outstanding_i(outstanding)
  );

  // Model: requests waiting for the bus, requests on the bus awaiting a response
  txn_t issue_q[$];
  txn_t flight_q[$];
  txn_t cur;
  bit   m_err_pend, m_proto, req_active;
  int   n_cmp = 0, n_mis = 0;
  int   rsp_pct = 60, gnt_pct = 75, new_pct = 70, oor_pct = 15;
  bit   spurious_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return a[31:28] == 4'h8;
  endfunction

  task automatic new_req();
    cur.we     = 1'($urandom_range(0, 1));
    cur.be     = 4'($urandom);
    cur.is_cap = 1'($urandom_range(0, 1));
    if (int'($urandom_range(0, 99)) < oor_pct)
      cur.addr = {4'($urandom_range(0, 7)), 26'($urandom), 2'b00};
    else
      cur.addr = {4'h8, 26'($urandom), 2'b00};
    cur.wdata  = {1'($urandom), 32'($urandom)};
    lsu_req    = 1'b1;
    lsu_we     = cur.we;
    lsu_be     = cur.be;
    lsu_is_cap = cur.is_cap;
    lsu_addr   = cur.addr;
    lsu_wdata  = cur.wdata;
  endtask

  task automatic cycle();
    bit credit, exp_gnt, inr;
    int eff;
    @(negedge clk);
    if (!req_active) begin
      lsu_req = 1'b0;
      if (int'($urandom_range(0, 99)) < new_pct) begin
        new_req();
        req_active = 1'b1;
      end
    end
    mem_gnt    = int'($urandom_range(0, 99)) < gnt_pct;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = {1'($urandom), 32'($urandom)};
    if (flight_q.size() != 0) begin
      if (int'($urandom_range(0, 99)) < rsp_pct) begin
        mem_rvalid = 1'b1;
        mem_err    = $urandom_range(0, 7) == 0;
      end
    end else if (spurious_en) begin
      mem_rvalid = 1'b1;
    end
    #1;
    credit  = mem_rvalid && (flight_q.size() != 0);
    eff     = issue_q.size() + flight_q.size() - int'(credit);
    inr     = in_window(lsu_addr);
    exp_gnt = 1'b0;
    if (lsu_req && !m_err_pend) begin
      if (inr) exp_gnt = (eff < MaxOut) && (issue_q.size() == 0 || mem_gnt);
      else     exp_gnt = (eff == 0);
    end
    check("lsu_gnt", 64'(lsu_gnt), 64'(exp_gnt));
    check("lsu_rvalid", 64'(lsu_rvalid), 64'(m_err_pend || credit));
    if (m_err_pend) begin
      check("reject_err", 64'(lsu_err), 64'(1'b1));
      check("reject_rdata", 64'(lsu_rdata), 64'(0));
    end else if (credit) begin
      check("rsp_err", 64'(lsu_err), 64'(mem_err));
      check("rsp_rdata", 64'(lsu_rdata), 64'(mem_rdata));
    end
    check("mem_req", 64'(mem_req), 64'(issue_q.size() != 0));
    if (issue_q.size() != 0) begin
      check("mem_addr", 64'(mem_addr), 64'(issue_q[0].addr));
      check("mem_wdata", 64'(mem_wdata), 64'(issue_q[0].wdata));
      check("mem_we", 64'(mem_we), 64'(issue_q[0].we));
      check("mem_be", 64'(mem_be), 64'(issue_q[0].be));
      check("mem_is_cap", 64'(mem_is_cap), 64'(issue_q[0].is_cap));
    end
    check("outstanding", 64'(outstanding), 64'(flight_q.size()));
    check("proto_err", 64'(proto_err), 64'(m_proto));
    if (credit) void'(flight_q.pop_front());
    else if (mem_rvalid) m_proto = 1'b1;
    m_err_pend = 1'b0;
    if (issue_q.size() != 0 && mem_gnt) flight_q.push_back(issue_q.pop_front());
    if (exp_gnt) begin
      if (inr) issue_q.push_back(cur);
      else     m_err_pend = 1'b1;
      req_active = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int  budget;
    int  sv_new, sv_rsp, sv_gnt;
    sv_new = new_pct; sv_rsp = rsp_pct; sv_gnt = gnt_pct;
    new_pct = 0; rsp_pct = 100; gnt_pct = 100;
    budget = 0;
    while ((req_active || m_err_pend || issue_q.size() != 0 || flight_q.size() != 0)
           && budget < 40) begin
      cycle();
      budget++;
    end
    check("drain_done", 64'(budget < 40), 64'(1'b1));
    cycle();
    new_pct = sv_new; rsp_pct = sv_rsp; gnt_pct = sv_gnt;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst_lsu_gnt", 64'(lsu_gnt), 64'(0));
    check("rst_lsu_rvalid", 64'(lsu_rvalid), 64'(0));
    check("rst_lsu_err", 64'(lsu_err), 64'(0));
    check("rst_lsu_rdata", 64'(lsu_rdata), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_fields", 64'({mem_we, mem_be, mem_is_cap}), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_proto_err", 64'(proto_err), 64'(0));
    issue_q.delete();
    flight_q.delete();
    m_err_pend = 1'b0; m_proto = 1'b0; req_active = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b1;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 4'h0; lsu_is_cap = 1'b0;
    lsu_addr = 32'h0; lsu_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    apply_reset();

    run(400);
    drain();

    rsp_pct = 0; gnt_pct = 50; new_pct = 90;
    run(20);
    rsp_pct = 50; oor_pct = 30;
    run(200);
    drain();

    spurious_en = 1'b1;
    cycle();
    spurious_en = 1'b0;
    new_pct = 0;
    run(5);

    new_pct = 100; oor_pct = 0; rsp_pct = 0; gnt_pct = 100;
    run(6);
    check("pre_reset_outstanding", 64'(outstanding), 64'(MaxOut));
    apply_reset();

    new_pct = 70; oor_pct = 15; rsp_pct = 60; gnt_pct = 75;
    run(300);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
